// File: rtl/obi2hwpe_ctrl_bridge.sv
// obi2hwpe_ctrl_bridge: OBI subordinate port to HWPE-ctrl target bridge.
// Tracks IDs, filters an address window and returns responses in order.
module obi2hwpe_ctrl_bridge #(
    parameter int unsigned          AddrWidth      = 32,
    parameter int unsigned          DataWidth      = 32,
    parameter int unsigned          IdWidth        = 1,
    parameter int unsigned          MaxOutstanding = 2,
    parameter logic [AddrWidth-1:0] BaseAddr       = '0,
    parameter logic [AddrWidth-1:0] WindowSize     = AddrWidth'('h100)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   obi_req_i,
    output logic                   obi_gnt_o,
    input  logic [AddrWidth-1:0]   obi_addr_i,
    input  logic                   obi_we_i,
    input  logic [DataWidth/8-1:0] obi_be_i,
    input  logic [DataWidth-1:0]   obi_wdata_i,
    input  logic [IdWidth-1:0]     obi_aid_i,
    output logic                   obi_rvalid_o,
    input  logic                   obi_rready_i,
    output logic [DataWidth-1:0]   obi_rdata_o,
    output logic                   obi_err_o,
    output logic [IdWidth-1:0]     obi_rid_o,
    output logic                   ctrl_req_o,
    input  logic                   ctrl_gnt_i,
    output logic [AddrWidth-1:0]   ctrl_add_o,
    output logic                   ctrl_wen_o,
    output logic [DataWidth/8-1:0] ctrl_be_o,
    output logic [DataWidth-1:0]   ctrl_data_o,
    output logic [IdWidth-1:0]     ctrl_id_o,
    input  logic                   ctrl_r_valid_i,
    input  logic [DataWidth-1:0]   ctrl_r_data_i,
    output logic                   unexp_rsp_o
);

    localparam int unsigned PtrW =
        (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    // Circular pointer advance for a depth that need not fill PtrW.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrLast) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] fwd_q, fwd_d;
    logic [CntW-1:0] dat_cnt_q, dat_cnt_d;
    logic [PtrW-1:0] trk_wr_q, trk_wr_d;
    logic [PtrW-1:0] trk_rd_q, trk_rd_d;
    logic [PtrW-1:0] dat_wr_q, dat_wr_d;
    logic [PtrW-1:0] dat_rd_q, dat_rd_d;
    logic            unexp_q, unexp_d;

    logic [MaxOutstanding-1:0][IdWidth-1:0]   trk_aid_q;
    logic [MaxOutstanding-1:0]                trk_err_q;
    logic [MaxOutstanding-1:0]                trk_we_q;
    logic [MaxOutstanding-1:0][DataWidth-1:0] dat_q;

    logic in_win, full, accept;
    logic trk_empty, dat_empty;
    logic head_err, head_we;
    logic rsp_ok, bypass, rvalid, rsp_pop;
    logic dat_push, dat_pop;

    assign in_win = (obi_addr_i - BaseAddr) < WindowSize;
    assign full   = (cnt_q == CntMax);

    assign trk_empty = (cnt_q == '0);
    assign dat_empty = (dat_cnt_q == '0);
    assign head_err  = trk_err_q[trk_rd_q];
    assign head_we   = trk_we_q[trk_rd_q];

    assign rsp_ok   = ctrl_r_valid_i & (fwd_q != '0);
    assign bypass   = dat_empty & ~head_err & rsp_ok & ~trk_empty;
    assign rvalid   = ~trk_empty & (head_err | ~dat_empty | bypass);
    assign rsp_pop  = rvalid & obi_rready_i;
    assign dat_pop  = rsp_pop & ~head_err & ~dat_empty;
    assign dat_push = rsp_ok & ~(bypass & rsp_pop);

    // Request path: forward in-window accesses, accept the rest locally.
    always_comb begin
        ctrl_req_o = 1'b0;
        obi_gnt_o  = 1'b0;
        if (in_win) begin
            ctrl_req_o = obi_req_i & ~full;
            obi_gnt_o  = ctrl_gnt_i & ~full;
        end else begin
            obi_gnt_o  = obi_req_i & ~full;
        end
    end

    assign accept      = obi_req_i & obi_gnt_o;
    assign ctrl_add_o  = obi_addr_i;
    assign ctrl_wen_o  = ~obi_we_i;
    assign ctrl_be_o   = obi_be_i;
    assign ctrl_data_o = obi_wdata_i;
    assign ctrl_id_o   = obi_aid_i;

    // Response fields come from the tracker head; data only for HWPE reads.
    always_comb begin
        obi_rvalid_o = rvalid;
        obi_rid_o    = '0;
        obi_err_o    = 1'b0;
        obi_rdata_o  = '0;
        if (!trk_empty) begin
            obi_rid_o = trk_aid_q[trk_rd_q];
            obi_err_o = head_err;
            if (!head_err && !head_we) begin
                obi_rdata_o = dat_empty ? ctrl_r_data_i : dat_q[dat_rd_q];
            end
        end
    end

    // Next-state for occupancy counters, pointers and the sticky flag.
    always_comb begin
        cnt_d     = cnt_q;
        fwd_d     = fwd_q;
        dat_cnt_d = dat_cnt_q;
        unexp_d   = unexp_q | (ctrl_r_valid_i & (fwd_q == '0));
        trk_wr_d  = accept ? ptr_inc(trk_wr_q) : trk_wr_q;
        trk_rd_d  = rsp_pop ? ptr_inc(trk_rd_q) : trk_rd_q;
        dat_wr_d  = dat_push ? ptr_inc(dat_wr_q) : dat_wr_q;
        dat_rd_d  = dat_pop ? ptr_inc(dat_rd_q) : dat_rd_q;
        if (accept && !rsp_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && rsp_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        if ((accept && in_win) && !rsp_ok) begin
            fwd_d = fwd_q + 1'b1;
        end else if (!(accept && in_win) && rsp_ok) begin
            fwd_d = fwd_q - 1'b1;
        end
        if (dat_push && !dat_pop) begin
            dat_cnt_d = dat_cnt_q + 1'b1;
        end else if (!dat_push && dat_pop) begin
            dat_cnt_d = dat_cnt_q - 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            fwd_q     <= '0;
            dat_cnt_q <= '0;
            trk_wr_q  <= '0;
            trk_rd_q  <= '0;
            dat_wr_q  <= '0;
            dat_rd_q  <= '0;
            unexp_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            fwd_q     <= fwd_d;
            dat_cnt_q <= dat_cnt_d;
            trk_wr_q  <= trk_wr_d;
            trk_rd_q  <= trk_rd_d;
            dat_wr_q  <= dat_wr_d;
            dat_rd_q  <= dat_rd_d;
            unexp_q   <= unexp_d;
        end
    end

    // Tracker and data FIFO storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trk_aid_q <= '0;
            trk_err_q <= '0;
            trk_we_q  <= '0;
            dat_q     <= '0;
        end else begin
            if (accept) begin
                trk_aid_q[trk_wr_q] <= obi_aid_i;
                trk_err_q[trk_wr_q] <= ~in_win;
                trk_we_q[trk_wr_q]  <= obi_we_i;
            end
            if (dat_push) begin
                dat_q[dat_wr_q] <= ctrl_r_data_i;
            end
        end
    end

    assign unexp_rsp_o = unexp_q;

endmodule

// File: tb/tb_obi2hwpe_ctrl_bridge.sv
// tb_obi2hwpe_ctrl_bridge: directed stimulus with a response scoreboard
// and a behavioural HWPE target with programmable latency.
module tb_obi2hwpe_ctrl_bridge;

    logic        clk;
    logic        rst_n;
    logic        obi_req_i;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i;
    logic        obi_we_i;
    logic [3:0]  obi_be_i;
    logic [31:0] obi_wdata_i;
    logic [1:0]  obi_aid_i;
    logic        obi_rvalid_o;
    logic        obi_rready_i;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;
    logic [1:0]  obi_rid_o;
    logic        ctrl_req_o;
    logic        ctrl_gnt_i;
    logic [31:0] ctrl_add_o;
    logic        ctrl_wen_o;
    logic [3:0]  ctrl_be_o;
    logic [31:0] ctrl_data_o;
    logic [1:0]  ctrl_id_o;
    logic        ctrl_r_valid_i;
    logic [31:0] ctrl_r_data_i;
    logic        unexp_rsp_o;

    obi2hwpe_ctrl_bridge #(
        .IdWidth (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .obi_req_i      (obi_req_i),
        .obi_gnt_o      (obi_gnt_o),
        .obi_addr_i     (obi_addr_i),
        .obi_we_i       (obi_we_i),
        .obi_be_i       (obi_be_i),
        .obi_wdata_i    (obi_wdata_i),
        .obi_aid_i      (obi_aid_i),
        .obi_rvalid_o   (obi_rvalid_o),
        .obi_rready_i   (obi_rready_i),
        .obi_rdata_o    (obi_rdata_o),
        .obi_err_o      (obi_err_o),
        .obi_rid_o      (obi_rid_o),
        .ctrl_req_o     (ctrl_req_o),
        .ctrl_gnt_i     (ctrl_gnt_i),
        .ctrl_add_o     (ctrl_add_o),
        .ctrl_wen_o     (ctrl_wen_o),
        .ctrl_be_o      (ctrl_be_o),
        .ctrl_data_o    (ctrl_data_o),
        .ctrl_id_o      (ctrl_id_o),
        .ctrl_r_valid_i (ctrl_r_valid_i),
        .ctrl_r_data_i  (ctrl_r_data_i),
        .unexp_rsp_o    (unexp_rsp_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 1;
    logic spur = 1'b0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } tgt_t;

    typedef struct {
        logic [1:0]  rid;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    tgt_t tq[$];
    exp_t sq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Target register contents seen by reads: 0x10 reads 0xCAFEBABE.
    function automatic logic [31:0] tgt_fn(input logic [31:0] a);
        return 32'hCAFEBABE ^ a ^ 32'h10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Target: record grants mid-cycle, answer lat cycles later.
    always @(negedge clk) begin
        if (rst_n && ctrl_req_o && ctrl_gnt_i) begin
            tq.push_back('{cyc + lat,
                           ctrl_wen_o ? tgt_fn(ctrl_add_o) : 32'h0});
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (!rst_n) tq.delete();
        if (tq.size() > 0 && tq[0].due <= cyc) begin
            ctrl_r_valid_i = 1'b1;
            ctrl_r_data_i  = tq[0].data;
            void'(tq.pop_front());
        end else begin
            ctrl_r_valid_i = spur;
            ctrl_r_data_i  = 32'hDEAD0000;
        end
    end

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        exp_t e;
        logic oow;
        if (rst_n) begin
            if (obi_rvalid_o && obi_rready_i) begin
                checks++;
                assert (sq.size() != 0) else begin
                    errors++;
                    $error("FAIL rsp_no_txn: rid=%0h expected none",
                           obi_rid_o);
                end
                if (sq.size() != 0) begin
                    e = sq.pop_front();
                    chk("sb_rid", 32'(obi_rid_o), 32'(e.rid));
                    chk("sb_err", 32'(obi_err_o), 32'(e.err));
                    chk("sb_rdata", obi_rdata_o, e.rdata);
                end
            end
            if (obi_req_i && obi_gnt_o) begin
                oow = !(obi_addr_i < 32'h100);
                e.rid   = obi_aid_i;
                e.err   = oow;
                e.rdata = (oow || obi_we_i) ? 32'h0 : tgt_fn(obi_addr_i);
                sq.push_back(e);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w,
                         input logic [1:0] id);
        int n;
        obi_req_i   = 1'b1;
        obi_addr_i  = a;
        obi_we_i    = w;
        obi_aid_i   = id;
        obi_be_i    = 4'hF;
        obi_wdata_i = a ^ 32'h5A5A5A5A;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!obi_gnt_o && n < 50);
        chk("gnt_timeout", 32'(obi_gnt_o), 32'h1);
        step();
        obi_req_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sq.size()), 32'h0);
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        obi_req_i    = 1'b0;
        obi_addr_i   = '0;
        obi_we_i     = 1'b0;
        obi_be_i     = '0;
        obi_wdata_i  = '0;
        obi_aid_i    = '0;
        obi_rready_i = 1'b1;
        ctrl_gnt_i   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_rvalid", 32'(obi_rvalid_o), 32'h0);
        chk("rst_unexp", 32'(unexp_rsp_o), 32'h0);
        chk("rst_ctrl_req", 32'(ctrl_req_o), 32'h0);
        chk("rst_gnt", 32'(obi_gnt_o), 32'h0);
        step();
        rst_n      = 1'b1;
        ctrl_gnt_i = 1'b1;

        // Single read with bypass response.
        @(negedge clk);
        chk("idle_rvalid", 32'(obi_rvalid_o), 32'h0);
        step();
        issue(32'h10, 1'b0, 2'd1);
        @(negedge clk);
        chk("rd_rvalid", 32'(obi_rvalid_o), 32'h1);
        chk("rd_rdata", obi_rdata_o, 32'hCAFEBABE);
        chk("rd_rid", 32'(obi_rid_o), 32'h1);
        chk("rd_err", 32'(obi_err_o), 32'h0);

        // Out-of-window write completes locally.
        step();
        obi_req_i  = 1'b1;
        obi_addr_i = 32'h200;
        obi_we_i   = 1'b1;
        obi_aid_i  = 2'd0;
        @(negedge clk);
        chk("oow_ctrl_req", 32'(ctrl_req_o), 32'h0);
        chk("oow_gnt", 32'(obi_gnt_o), 32'h1);
        step();
        obi_req_i = 1'b0;
        @(negedge clk);
        chk("oow_rvalid", 32'(obi_rvalid_o), 32'h1);
        chk("oow_err", 32'(obi_err_o), 32'h1);
        chk("oow_rdata", obi_rdata_o, 32'h0);
        chk("oow_no_ctrl", 32'(ctrl_req_o), 32'h0);

        // Full with back-pressure.
        step();
        obi_rready_i = 1'b0;
        issue(32'h20, 1'b0, 2'd0);
        issue(32'h24, 1'b0, 2'd1);
        obi_req_i  = 1'b1;
        obi_addr_i = 32'h28;
        obi_we_i   = 1'b0;
        obi_aid_i  = 2'd2;
        repeat (3) begin
            @(negedge clk);
            chk("full_gnt", 32'(obi_gnt_o), 32'h0);
            chk("full_ctrl_req", 32'(ctrl_req_o), 32'h0);
            chk("hold_rid", 32'(obi_rid_o), 32'h0);
            chk("hold_rdata", obi_rdata_o, tgt_fn(32'h20));
        end
        step();
        obi_rready_i = 1'b1;
        @(negedge clk);
        chk("hs_cycle_gnt", 32'(obi_gnt_o), 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!obi_gnt_o && n < 20);
        chk("gnt_after_pop", 32'(obi_gnt_o), 32'h1);
        step();
        obi_req_i = 1'b0;
        wait_idle();

        // Mixed ordering with 3-cycle target latency.
        lat = 3;
        step();
        issue(32'h30, 1'b0, 2'd0);
        issue(32'h300, 1'b0, 2'd1);
        issue(32'h34, 1'b1, 2'd0);
        wait_idle();

        // Spurious target response.
        step();
        spur = 1'b1;
        @(negedge clk);
        chk("spur_rvalid", 32'(obi_rvalid_o), 32'h0);
        step();
        spur = 1'b0;
        @(negedge clk);
        chk("spur_unexp", 32'(unexp_rsp_o), 32'h1);
        repeat (3) step();
        @(negedge clk);
        chk("spur_sticky", 32'(unexp_rsp_o), 32'h1);
        chk("spur_no_rsp", 32'(obi_rvalid_o), 32'h0);

        // Reset with two transactions outstanding.
        lat = 6;
        step();
        issue(32'h40, 1'b0, 2'd0);
        issue(32'h44, 1'b0, 2'd1);
        rst_n      = 1'b0;
        ctrl_gnt_i = 1'b0;
        sq.delete();
        @(negedge clk);
        chk("mrst_rvalid", 32'(obi_rvalid_o), 32'h0);
        chk("mrst_unexp", 32'(unexp_rsp_o), 32'h0);
        chk("mrst_gnt", 32'(obi_gnt_o), 32'h0);
        chk("mrst_ctrl_req", 32'(ctrl_req_o), 32'h0);
        chk("mrst_rdata", obi_rdata_o, 32'h0);
        chk("mrst_rid", 32'(obi_rid_o), 32'h0);
        chk("mrst_err", 32'(obi_err_o), 32'h0);
        step();
        rst_n      = 1'b1;
        ctrl_gnt_i = 1'b1;
        lat        = 1;
        @(negedge clk);
        chk("post_rst_rvalid", 32'(obi_rvalid_o), 32'h0);
        chk("post_rst_not_full", 32'(obi_gnt_o), 32'h1);
        step();
        issue(32'h50, 1'b0, 2'd3);
        @(negedge clk);
        chk("post_rst_rd_rvalid", 32'(obi_rvalid_o), 32'h1);
        chk("post_rst_rd_rdata", obi_rdata_o, tgt_fn(32'h50));
        wait_idle();
        repeat (8) @(negedge clk);
        chk("post_rst_unexp", 32'(unexp_rsp_o), 32'h0);
        chk("post_rst_idle", 32'(obi_rvalid_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/obi2hwpe_ctrl_bridge.md
# obi2hwpe_ctrl_bridge

Parametrised, buffered bridge from a tile-side OBI subordinate port to an HWPE peripheral control target (RedMulE or any HWPE-ctrl slave). It adds:
- OBI transaction IDs and optional `rready` back-pressure, with a bounded number of outstanding transactions.
- An address-window check that completes out-of-window accesses locally with `err=1`.
- Strictly in-order responses.

It sits between the tile crossbar/core data port and the accelerator control register file.

## Interface
Parameters:
- AddrWidth, 32, OBI/HWPE address width.
- DataWidth, 32, data width; BE width is DataWidth/8.
- IdWidth, 1, OBI `aid`/`rid` width (≥1).
- MaxOutstanding, 2, maximum accepted-but-not-responded transactions; power of two, ≥1.
- BaseAddr, 32'h0, window base.
- WindowSize, 32'h100, window size in bytes; an address is in-window iff (addr − BaseAddr) < WindowSize, computed unsigned in AddrWidth bits.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; one clock; asynchronous, active-low.
- obi_req_i / obi_gnt_o  in/out  1  OBI address-channel handshake.
- obi_addr_i  in  AddrWidth  byte address.
- obi_we_i  in  1  1 = write.
- obi_be_i  in  DataWidth/8  byte enables.
- obi_wdata_i  in  DataWidth  write data.
- obi_aid_i  in  IdWidth  transaction ID.
- obi_rvalid_o / obi_rready_i  out/in  1  OBI response handshake. Tie `obi_rready_i` to 1 if unused.
- obi_rdata_o  out  DataWidth  read data; 0 for writes and errors.
- obi_err_o  out  1  response error.
- obi_rid_o  out  IdWidth  echoed `aid`.
- ctrl_req_o / ctrl_gnt_i  out/in  1  HWPE-ctrl request handshake.
- ctrl_add_o  out  AddrWidth  full `obi_addr_i`.
- ctrl_wen_o  out  1  `~obi_we_i` (1 = read).
- ctrl_be_o, ctrl_data_o  out  DataWidth/8, DataWidth  pass-through.
- ctrl_id_o  out  IdWidth  `obi_aid_i`, informational only.
- ctrl_r_valid_i  in  1  target response strobe; cannot be back-pressured.
- ctrl_r_data_i  in  DataWidth  target read data.
- unexp_rsp_o  out  1  sticky flag: `ctrl_r_valid_i` arrived with no forwarded transaction pending.

## Operation
State:
- `cnt`, 0..MaxOutstanding: outstanding transactions.
- Tracker FIFO, depth MaxOutstanding, entries {aid, err}; one entry per accepted transaction.
- `fwd_cnt`: forwarded transactions still awaiting `ctrl_r_valid_i`.
- Data FIFO, depth MaxOutstanding: HWPE responses not yet delivered.

Request path (combinational), with `full` = (`cnt` == MaxOutstanding):
- In-window: `ctrl_req_o` = `obi_req_i` & ~`full`, and `obi_gnt_o` = `ctrl_gnt_i` & ~`full`.
- Out-of-window: `ctrl_req_o` = 0, and `obi_gnt_o` = `obi_req_i` & ~`full` (local accept).

Accept (`obi_req_i` & `obi_gnt_o`):
- Push {`obi_aid_i`, ~in_window} into the tracker.
- Increment `cnt`.
- Increment `fwd_cnt` if in-window.

Target response (`ctrl_r_valid_i`):
- If `fwd_cnt` == 0: set `unexp_rsp_o` and discard the response.
- Otherwise, decrement `fwd_cnt` and either push the data into the data FIFO or bypass it (see below).

Response path (`H` = tracker head):
- `obi_rvalid_o` = tracker not empty & (H.err | data FIFO not empty | bypass).
- Bypass condition: data FIFO empty & ~H.err & `ctrl_r_valid_i`.
- Response fields: `obi_rid_o` = H.aid and `obi_err_o` = H.err.
- `obi_rdata_o`: 0 if H.err; otherwise the data FIFO head, or `ctrl_r_data_i` on bypass.
- On `obi_rvalid_o` & `obi_rready_i`:
  - Pop the tracker and decrement `cnt`.
  - If ~H.err, pop the data FIFO; on bypass, do not push.
- A bypassed response not taken because `obi_rready_i` = 0 is pushed into the data FIFO.

Ordering:
- Err entries never consume data.
- Data belongs to the oldest non-err entry.
- Responses leave in acceptance order.

Concurrency:
- Accept and response may occur in the same cycle; `cnt` then stays unchanged.
- Accept while `full` is impossible, so `gnt` stays low.
- The data FIFO cannot overflow because data FIFO occupancy ≤ `cnt`.

Target assumption: the target returns exactly one `ctrl_r_valid_i` per granted request (read or write), in order, ≥1 cycle after `gnt`.

Reset (any time, including mid-transaction):
- `cnt`, `fwd_cnt`, both FIFOs and `unexp_rsp_o` clear to 0.
- Outstanding transactions are dropped.
- `obi_rvalid_o` = 0 while `rst_ni` is low.

## Timing
- Request path is combinational: `ctrl_req_o`/`obi_gnt_o` follow `obi_req_i` and `ctrl_gnt_i` in the same cycle.
- HWPE read/write response: 0-cycle latency on bypass; otherwise delivered the cycle `obi_rready_i` is high and the entry is at the head.
- Error response: `obi_rvalid_o` earliest 1 cycle after the accept edge (tracker is registered).
- Throughput: 1 transaction/cycle sustained with `obi_rready_i` = 1 and a 1-cycle target.
- `obi_rid_o`/`obi_rdata_o`/`obi_err_o` are held stable while `obi_rvalid_o` & ~`obi_rready_i`.

## Test plan
- **Single read:** read 0x10, aid=1; target `gnt` immediately, `r_valid` next cycle, data 0xCAFEBABE, `rready`=1 → `obi_rvalid_o` that cycle, `rdata`=0xCAFEBABE, `rid`=1, `err`=0.
- **Out-of-window write:** write 0x200 with WindowSize=0x100 → `ctrl_req_o` never asserted; `gnt` same cycle; response next cycle with `err`=1, `rdata`=0.
- **Full and back-pressure:** MaxOutstanding=2, `rready`=0, three back-to-back reads → third request sees `gnt`=0 until the first response handshake; responses return in order with aids 0,1,2 and correct data.
- **Mixed ordering:** in-window read (aid 0), out-of-window read (aid 1), in-window write (aid 0), with a 3-cycle target latency → `rid` sequence 0,1,0; `err` sequence 0,1,0; the err response does not overtake the first.
- **Spurious target response:** `ctrl_r_valid_i` with `fwd_cnt`=0 → `unexp_rsp_o`=1 sticky, no OBI response; cleared only by reset.
- **Reset mid-transaction:** assert `rst_ni`=0 with 2 outstanding → all outputs 0, `cnt`=0 after release; a new read completes normally.
